// File: rtl/star_trig_pkg.sv
// Shared constants and the event record type for the star-trigger receive path.
package star_trig_pkg;
  localparam int STAR_NUM_LINES = 17;
  localparam int STAR_TS_W      = 32;
  localparam int STAR_DEPTH     = 16;
  localparam int STAR_FILT_CYC  = 4;
  localparam int DROP_CNT_W     = 8;

  typedef struct packed {
    logic [STAR_TS_W-1:0]      ts;
    logic [STAR_NUM_LINES-1:0] mask;
  } star_evt_t;
endpackage

// File: rtl/star_trig_evt_fifo.sv
// Synchronous event FIFO, default word is one star_evt_t; shared with the TX-side event log.
module star_trig_evt_fifo import star_trig_pkg::*; #(
  parameter int DW    = $bits(star_evt_t),
  parameter int DEPTH = STAR_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [DW-1:0]          din_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/star_trig_rx.sv
// Star-trigger receiver: 2-FF sync, optional deglitch, rise detect, timestamped event FIFO.
// Defining STAR_TRIG_RX_FILTER_EN adds the per-line FILT_CYC stability filter.
module star_trig_rx import star_trig_pkg::*; #(
  parameter int NUM_LINES = STAR_NUM_LINES,
  parameter int TS_W      = STAR_TS_W,
  parameter int DEPTH     = STAR_DEPTH,
  parameter int FILT_CYC  = STAR_FILT_CYC
) (
  input  logic                   clk,
  input  logic                   cpu_rst_b,
  input  logic [NUM_LINES-1:0]   star_in,
  input  logic                   rx_en,
  input  logic [NUM_LINES-1:0]   line_mask,
  input  logic                   ts_clr,
  input  logic                   ovf_clr,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W-1:0]        evt_ts,
  output logic [NUM_LINES-1:0]   evt_mask,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   ovf,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);
  localparam int EW = TS_W + NUM_LINES;

  logic [NUM_LINES-1:0]  sync1_q, sync2_q, level, level_d_q, rise;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic                  det_vld_q;
  logic [TS_W-1:0]       det_ts_q;
  logic [NUM_LINES-1:0]  det_mask_q;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  fifo_full, fifo_empty, pop, drop;
  logic [EW-1:0]         head;

  if (FILT_CYC < 1 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2) begin : g_bad_param
    $error("star_trig_rx: FILT_CYC must be >= 1 and DEPTH a power of two >= 2");
  end

  always_ff @(posedge clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= star_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef STAR_TRIG_RX_FILTER_EN
  localparam int CW = $clog2(FILT_CYC + 1);

  logic [NUM_LINES-1:0] filt_q;
  logic [CW-1:0]        fcnt_q [NUM_LINES];

  // A line flips only after FILT_CYC consecutive cycles at the new level.
  always_ff @(posedge clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        fcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == CW'(FILT_CYC - 1)) begin
            filt_q[i] <= sync2_q[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + CW'(1);
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign rise = level & ~level_d_q & line_mask;
  assign ts_d = ts_clr ? '0 : ts_q + TS_W'(1);

  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign drop      = det_vld_q & fifo_full & ~pop;
  assign evt_ts    = head[EW-1 -: TS_W];
  assign evt_mask  = head[NUM_LINES-1:0];
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;

  // A drop in the same cycle as ovf_clr wins and restarts the count at one.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = ovf_clr ? DROP_CNT_W'(1) : ((&drop_q) ? drop_q : drop_q + DROP_CNT_W'(1));
    end else if (ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      ts_q       <= '0;
      level_d_q  <= '0;
      det_vld_q  <= 1'b0;
      det_ts_q   <= '0;
      det_mask_q <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      level_d_q  <= level;
      det_vld_q  <= rx_en & (|rise);
      det_ts_q   <= ts_q;
      det_mask_q <= rise;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  star_trig_evt_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (cpu_rst_b),
    .push_i  (det_vld_q),
    .din_i   ({det_ts_q, det_mask_q}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );
endmodule

// File: tb/tb_star_trig_rx.sv
// Bench for star_trig_rx (TS_W=8 so the timestamp wraps), checked against a history-based event model.
module tb_star_trig_rx;
  localparam int NL    = 17;
  localparam int TSW   = 8;
  localparam int DEPTH = 16;
  localparam int FILT  = 4;
`ifdef STAR_TRIG_RX_FILTER_EN
  localparam int FLAT  = FILT;
`else
  localparam int FLAT  = 0;
`endif
  localparam int LAT       = 3 + FLAT;
  localparam int PW        = 6;
  localparam int SHORT_EXP = (FLAT > 0) ? 0 : 1;

  logic          clk = 1'b0;
  logic          cpu_rst_b;
  logic [NL-1:0] star_in, line_mask;
  logic          rx_en, ts_clr, ovf_clr, evt_ready;
  logic          evt_valid, ovf;
  logic [TSW-1:0] evt_ts;
  logic [NL-1:0] evt_mask;
  logic [4:0]    fifo_cnt;
  logic [7:0]    drop_cnt;

  star_trig_rx #(.NUM_LINES(NL), .TS_W(TSW), .DEPTH(DEPTH), .FILT_CYC(FILT)) dut (
    .clk(clk), .cpu_rst_b(cpu_rst_b), .star_in(star_in), .rx_en(rx_en),
    .line_mask(line_mask), .ts_clr(ts_clr), .ovf_clr(ovf_clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_mask(evt_mask),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TSW-1:0] ts;
    logic [NL-1:0]  mask;
  } ev_t;

  ev_t            q[$];
  logic [NL-1:0]  hist[8];
  logic [NL-1:0]  lvl[2];
  bit             pend_v;
  ev_t            pend;
  logic [TSW-1:0] m_ts;
  bit             m_ovf;
  int             m_drop;
  int             vectors = 0;
  int             errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) hist[i] = '0;
    lvl[0] = '0;
    lvl[1] = '0;
    pend_v = 0;
    m_ts   = '0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  // Input sampled at edge N appears as the level at N+1 (+FILT when filtered),
  // is detected at N+2 with the timestamp of the preceding cycle, and enters the FIFO at N+3.
  task automatic model_step();
    bit pop, drop, flip;
    logic [NL-1:0] rise, nl;
    pop  = evt_ready && (q.size() > 0);
    drop = pend_v && (q.size() == DEPTH) && !pop;
    if (drop) begin
      m_ovf  = 1;
      m_drop = ovf_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (ovf_clr) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    if (pop) void'(q.pop_front());
    if (pend_v && !drop) q.push_back(pend);
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = star_in;
    rise = lvl[0] & ~lvl[1] & line_mask;
    pend_v    = rx_en && (rise != '0);
    pend.ts   = m_ts;
    pend.mask = rise;
`ifdef STAR_TRIG_RX_FILTER_EN
    nl = lvl[0];
    for (int b = 0; b < NL; b++) begin
      flip = 1;
      for (int j = 2; j < FILT + 2; j++) if (hist[j][b] == lvl[0][b]) flip = 0;
      if (flip) nl[b] = ~lvl[0][b];
    end
`else
    nl = hist[1];
`endif
    lvl[1] = lvl[0];
    lvl[0] = nl;
    m_ts = ts_clr ? '0 : m_ts + 8'd1;
  endtask

  task automatic check_outputs();
    chk("evt_valid", evt_valid, q.size() > 0);
    chk("fifo_cnt", fifo_cnt, q.size());
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (q.size() > 0) begin
      chk("evt_ts", evt_ts, q[0].ts);
      chk("evt_mask", evt_mask, q[0].mask);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!cpu_rst_b) model_reset();
    else model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!evt_valid && n < 40) begin
      cycle();
      n++;
    end
    chk("wait_valid_bound", evt_valid, 1);
  endtask

  task automatic pulse(input int line, input int width);
    star_in[line] = 1'b1;
    repeat (width) cycle();
    star_in[line] = 1'b0;
    repeat (PW) cycle();
  endtask

  initial begin
    int n;
    logic [TSW-1:0] t0, exp_ts;

    cpu_rst_b = 1'b0;
    star_in = '0; line_mask = '1; rx_en = 1'b0;
    ts_clr = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_mask", evt_mask, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0);
    repeat (3) cycle();
    cpu_rst_b = 1'b1;
    rx_en = 1'b1;
    repeat (4) cycle();

    // single pulse on line 3, held 10 cycles
    star_in[3] = 1'b1;
    t0 = m_ts;
    wait_valid(n);
    exp_ts = t0 + 8'(2 + FLAT);
    chk("single_latency", n - 1, LAT);
    chk("single_mask", evt_mask, 17'h00008);
    chk("single_ts", evt_ts, exp_ts);
    repeat (10 - n) cycle();
    star_in[3] = 1'b0;
    repeat (8) cycle();
    chk("single_count", fifo_cnt, 1);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    chk("single_popped", fifo_cnt, 0);

    // lines 0 and 16 together
    star_in = 17'h10001;
    wait_valid(n);
    chk("simul_mask", evt_mask, 17'h10001);
    repeat (PW) cycle();
    star_in = '0;
    repeat (PW) cycle();
    chk("simul_count", fifo_cnt, 1);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;

    // masked-off line 5
    line_mask = '1;
    line_mask[5] = 1'b0;
    pulse(5, PW + 2);
    pulse(5, PW + 2);
    chk("masked_cnt", fifo_cnt, 0);
    line_mask = '1;

    // level already high when rx_en asserts
    rx_en = 1'b0;
    star_in[7] = 1'b1;
    repeat (PW + 4) cycle();
    rx_en = 1'b1;
    repeat (10) cycle();
    chk("preheld_cnt", fifo_cnt, 0);
    star_in[7] = 1'b0;
    repeat (PW + 2) cycle();

    // 3-cycle and 4-cycle pulses
    pulse(2, 3);
    repeat (6) cycle();
    chk("short3_cnt", fifo_cnt, SHORT_EXP);
    evt_ready = 1'b1; repeat (2) cycle(); evt_ready = 1'b0;
    pulse(2, 4);
    repeat (6) cycle();
    chk("pulse4_cnt", fifo_cnt, 1);
    evt_ready = 1'b1; repeat (2) cycle(); evt_ready = 1'b0;

    // ts_clr then a rise sampled 5 edges later
    ts_clr = 1'b1; cycle(); ts_clr = 1'b0;
    repeat (4) cycle();
    star_in[9] = 1'b1;
    wait_valid(n);
    chk("ts_after_clr", evt_ts, 6 + FLAT);
    star_in[9] = 1'b0;
    repeat (PW + 2) cycle();
    evt_ready = 1'b1; repeat (2) cycle(); evt_ready = 1'b0;

    // overflow: 18 events, no consumer
    for (int p = 0; p < 18; p++) pulse(1, PW);
    repeat (8) cycle();
    chk("ovf_cnt", fifo_cnt, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_drop", drop_cnt, 2);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovfclr_flag", ovf, 0);
    chk("ovfclr_drop", drop_cnt, 0);

    // full FIFO, pop coincides with the push
    star_in[1] = 1'b1;
    n = 0;
    while (!pend_v && n < 20) begin
      cycle();
      n++;
    end
    chk("fullpop_pend", pend_v, 1);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    chk("fullpop_cnt", fifo_cnt, 16);
    chk("fullpop_ovf", ovf, 0);
    chk("fullpop_drop", drop_cnt, 0);
    star_in[1] = 1'b0;
    repeat (PW) cycle();
    evt_ready = 1'b1; repeat (20) cycle(); evt_ready = 1'b0;
    chk("drain_cnt", fifo_cnt, 0);

    // idle across a timestamp wrap, then an event after the wrap
    repeat (300) cycle();
    chk("wrap_idle_cnt", fifo_cnt, 0);
    pulse(12, PW);
    repeat (4) cycle();
    chk("wrap_evt_cnt", fifo_cnt, 1);
    evt_ready = 1'b1; repeat (2) cycle(); evt_ready = 1'b0;

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NL; i++) if ($urandom_range(7) == 0) star_in[i] = ~star_in[i];
      line_mask = ($urandom_range(3) == 0) ? 17'($urandom) : '1;
      rx_en     = ($urandom_range(9) != 0);
      evt_ready = ($urandom_range(2) == 0);
      ts_clr    = ($urandom_range(49) == 0);
      ovf_clr   = ($urandom_range(29) == 0);
      cycle();
    end
    ts_clr = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b0;
    line_mask = '1; rx_en = 1'b1;
    star_in = '0;
    repeat (PW) cycle();
    for (int p = 0; p < 3; p++) pulse(4 + p, PW);

    // asynchronous reset mid-stream
    #2;
    cpu_rst_b = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", evt_valid, 0);
    chk("midrst_cnt", fifo_cnt, 0);
    chk("midrst_ovf", ovf, 0);
    repeat (2) cycle();
    cpu_rst_b = 1'b1;

    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NL; i++) if ($urandom_range(5) == 0) star_in[i] = ~star_in[i];
      evt_ready = ($urandom_range(3) == 0);
      ovf_clr   = ($urandom_range(40) == 0);
      cycle();
    end
    ovf_clr = 1'b0;
    star_in = '0;
    repeat (PW + 4) cycle();
    evt_ready = 1'b1; repeat (30) cycle(); evt_ready = 1'b0;
    chk("final_cnt", fifo_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/star_trig_rx.md
Name: star_trig_rx

Overview:
- Receive-side counterpart of the star-trigger output bus: samples the 17 asynchronous DSTARC trigger lines, synchronizes them, and optionally deglitches them.
- Detects rising edges and records each trigger event as {timestamp, line mask} in an event FIFO.
- Firmware on the CPU sub-system, or the sequencer, drains the FIFO through a valid/ready stream.
- Sits in AQTC_top between the DSTARC input buffers and the APB trigger register block.

Parameters:
NUM_LINES, 17, number of star trigger lines
TS_W, 32, timestamp counter width
DEPTH, 16, event FIFO depth (power of two)
FILT_CYC, 4, cycles a new level must be stable before it is accepted (filter build only)

Ports:
clk  in  1  system clock
cpu_rst_b  in  1  asynchronous active-low reset
star_in  in  NUM_LINES  asynchronous trigger lines
rx_en  in  1  capture enable
line_mask  in  NUM_LINES  per-line enable, 1 = line captured
ts_clr  in  1  one-cycle pulse, zeroes the timestamp counter
ovf_clr  in  1  one-cycle pulse, clears ovf and drop_cnt
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_ts  out  TS_W  timestamp of head event
evt_mask  out  NUM_LINES  lines that rose in head event
fifo_cnt  out  $clog2(DEPTH)+1  current occupancy
ovf  out  1  sticky: an event was dropped
drop_cnt  out  8  dropped events, saturates at 255

Behaviour:
- Reset (cpu_rst_b low, asynchronous): all outputs, sync/filter/edge registers, timestamp and FIFO pointers go to 0.
- Sync: each line passes through a 2-FF synchronizer with reset value 0.
- Timestamp: free-running counter, +1 per cycle, wraps from 2^TS_W-1 to 0.
  - ts_clr loads 0 on the next edge, taking priority over the increment.
  - The counter runs regardless of rx_en.
- Edge detect: rise = level & ~level_d & line_mask. level is the synced value, or the filtered value in the filter build.
  - An event is generated when rx_en=1 and rise≠0.
  - evt_mask = rise; evt_ts = counter value in the detection cycle.
  - Several lines rising in the same cycle give one event with multiple mask bits.
- Latency, no filter: star_in sampled high at edge N gives detection at edge N+2; the event is written at edge N+3, so evt_valid=1 after N+3 when the FIFO was empty.
- Levels high at rx_en assertion produce no event; only 0→1 transitions count.
- rx_en=0 drops nothing and counts nothing; the sync path keeps running.
- FIFO: push on event; pop on evt_valid & evt_ready. Outputs are registered from the head, with no combinational path from evt_ready to evt_valid.
  - Full with no pop in the same cycle: the event is discarded, ovf←1 and drop_cnt +1 (saturating at 255).
  - Full with a pop in the same cycle: the push is accepted and fifo_cnt is unchanged.
  - Empty with a push in the same cycle: evt_valid rises on the next edge.
  - ovf_clr clears ovf and drop_cnt. If a drop happens in the same cycle, ovf=1 and drop_cnt=1.
- Mid-operation reset: FIFO contents are lost, evt_valid=0, and the timestamp restarts at 0.

Optional Feature:
- Macro: STAR_TRIG_RX_FILTER_EN.
- Defined: per-line counter after the synchronizer. The filtered level changes only after the synced level differs from it for FILT_CYC consecutive cycles; any return to the old level resets the counter. Pulses shorter than FILT_CYC are suppressed, and latency grows by FILT_CYC cycles.
- Undefined: the filtered level is the synced level, no counters are instantiated, and FILT_CYC is ignored.

Decomposition:
- Package star_trig_pkg holds:
  - STAR_NUM_LINES = 17 and STAR_TS_W = 32;
  - typedef star_evt_t = struct {ts, mask};
  - DROP_CNT_W = 8.
- One sub-module: star_trig_evt_fifo, a synchronous FIFO of star_evt_t with push/pop, full/empty and count. It is reusable by the TX-side event log.

Test Plan:
- Single pulse: rx_en=1, line_mask=all ones, star_in[3] 0→1 held 10 cycles at timestamp T → exactly one event, evt_mask=17'h00008, evt_ts=T+2 relative to the input edge, evt_valid high 3 cycles after the edge.
- Simultaneous rise: lines 0 and 16 rise on the same edge → one event with mask 17'h10001. Line 5 masked off (line_mask[5]=0) and toggled → no event.
- Overflow: evt_ready=0, 18 separate pulses → fifo_cnt=16, ovf=1, drop_cnt=2. Then ovf_clr → ovf=0, drop_cnt=0. Drain → 16 events with increasing timestamps.
- Full with concurrent pop: FIFO full, evt_ready=1 in the same cycle as a new event → no drop, fifo_cnt stays 16.
- Timestamp: ts_clr pulse, then a pulse 5 cycles later → evt_ts=5+sync offset. With TS_W=8, the counter wraps 255→0 without a spurious event.
- Filter build (STAR_TRIG_RX_FILTER_EN, FILT_CYC=4): a 3-cycle pulse gives no event; a 4-cycle pulse gives one event with latency 3+4. Assert cpu_rst_b low mid-stream → evt_valid=0, fifo_cnt=0 immediately.
